sde_ps_wr_fsm: RTL and testbench

//  PCIS write-address front end for the SDE PCIS accumulator stage. Accepts one AXI4 AW burst at a time from the

---
 rtl/sde_pkg.sv | 14 +
 rtl/sde_ps_bresp_fifo.sv | 55 +++++
 rtl/sde_ps_wr_fsm.sv | 138 +++++++++++++
 tb/tb_sde_ps_wr_fsm.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sde_pkg.sv
// Shared types and constants for the SDE PCIS write path.
// State encoding, AXI response codes and the PCIS beat size.
package sde_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } sde_wr_state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam int PCIS_BEAT_BYTES = 64;

endpackage

// File: rtl/sde_ps_bresp_fifo.sv
// Small synchronous FIFO holding the IDs of completed write bursts.
// Head entry reads as zero while the FIFO is empty.
module sde_ps_bresp_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_wdata,
    input  logic                       i_pop,
    output logic [W-1:0]               o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Storage array; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; push and pop in one cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/sde_ps_wr_fsm.sv
// PCIS write-address front end: one AW burst at a time, per-beat
// address generation for the accumulator, B responses via an ID FIFO.
module sde_ps_wr_fsm
    import sde_pkg::*;
#(
    parameter int PCIS_DATA_WIDTH  = 512,
    parameter int PCIS_ADDR_WIDTH  = 64,
    parameter int PCIS_ID_WIDTH    = 16,
    parameter int BRESP_FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PCIS_ID_WIDTH-1:0]   pcis_awid,
    input  logic [PCIS_ADDR_WIDTH-1:0] pcis_awaddr,
    input  logic [7:0]                 pcis_awlen,
    input  logic                       pcis_awvalid,
    output logic                       pcis_awready,
    input  logic                       pcis_wvalid,
    input  logic                       pcis_wready,
    input  logic                       pcis_wlast,
    output logic [PCIS_ID_WIDTH-1:0]   pcis_bid,
    output logic [1:0]                 pcis_bresp,
    output logic                       pcis_bvalid,
    input  logic                       pcis_bready,
    output logic                       pcis_req_wr,
    output logic [PCIS_ADDR_WIDTH-1:0] pcis_req_addr,
    output logic                       wlast_error
);

    localparam int BEAT = PCIS_DATA_WIDTH / 8;
    localparam int CW   = $clog2(BRESP_FIFO_DEPTH) + 1;

    localparam logic [PCIS_ADDR_WIDTH-1:0] BEAT_MASK = PCIS_ADDR_WIDTH'(BEAT - 1);
    localparam logic [PCIS_ADDR_WIDTH-1:0] BEAT_INC  = PCIS_ADDR_WIDTH'(BEAT);

    sde_wr_state_t              r_state;
    logic                       r_awready;
    logic                       r_req_wr;
    logic [PCIS_ADDR_WIDTH-1:0] r_req_addr;
    logic                       r_wlast_err;
    logic [PCIS_ID_WIDTH-1:0]   r_id;
    logic [7:0]                 r_len;
    logic [7:0]                 r_beat_cnt;

    logic                       w_aw_hs;
    logic                       w_beat;
    logic                       w_last;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_empty;
    logic [CW-1:0]              w_count;
    logic [CW-1:0]              w_count_nxt;
    logic                       w_full_nxt;
    logic [PCIS_ID_WIDTH-1:0]   w_head_id;

    assign w_aw_hs     = pcis_awvalid & r_awready;
    assign w_beat      = (r_state == DATA) & pcis_wvalid & pcis_wready;
    assign w_last      = (r_beat_cnt == r_len);
    assign w_push      = w_beat & w_last;
    assign w_pop       = ~w_empty & pcis_bready;
    assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);
    // Look-ahead full lets awready rise right after a pop and
    // guarantees a burst is never accepted without a free B slot.
    assign w_full_nxt  = (w_count_nxt == CW'(BRESP_FIFO_DEPTH));

    sde_ps_bresp_fifo #(
        .W     (PCIS_ID_WIDTH),
        .DEPTH (BRESP_FIFO_DEPTH)
    ) u_bfifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (r_id),
        .i_pop   (w_pop),
        .o_rdata (w_head_id),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Burst FSM: AW capture, beat counting, address stepping, wlast check.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_awready   <= 1'b0;
            r_req_wr    <= 1'b0;
            r_req_addr  <= '0;
            r_wlast_err <= 1'b0;
            r_id        <= '0;
            r_len       <= '0;
            r_beat_cnt  <= '0;
        end else begin
            r_wlast_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_awready <= ~w_full_nxt;
                    if (w_aw_hs) begin
                        r_awready  <= 1'b0;
                        r_id       <= pcis_awid;
                        r_len      <= pcis_awlen;
                        r_beat_cnt <= '0;
                        r_req_addr <= pcis_awaddr;
                        r_req_wr   <= 1'b1;
                        r_state    <= DATA;
                    end
                end
                DATA: begin
                    r_awready <= 1'b0;
                    if (w_beat) begin
                        r_wlast_err <= pcis_wlast ^ w_last;
                        if (w_last) begin
                            r_req_wr  <= 1'b0;
                            r_awready <= ~w_full_nxt;
                            r_state   <= IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                            r_req_addr <= (r_req_addr & ~BEAT_MASK) + BEAT_INC;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pcis_awready  = r_awready;
    assign pcis_req_wr   = r_req_wr;
    assign pcis_req_addr = r_req_addr;
    assign wlast_error   = r_wlast_err;
    assign pcis_bvalid   = ~w_empty;
    assign pcis_bid      = w_head_id;
    assign pcis_bresp    = AXI_RESP_OKAY;

    logic w_unused;
    assign w_unused = w_full;

endmodule

// File: tb/tb_sde_ps_wr_fsm.sv
// Directed bench for sde_ps_wr_fsm: bursts, address stepping,
// B FIFO back-pressure, wlast checking, mid-burst reset and wrap.
module tb_sde_ps_wr_fsm;

    logic        clk;
    logic        rst;
    logic [15:0] awid;
    logic [63:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic        wvalid;
    logic        wready;
    logic        wlast;
    logic [15:0] bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        req_wr;
    logic [63:0] req_addr;
    logic        wlast_err;

    int tests = 0;
    int fails = 0;

    sde_ps_wr_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .pcis_awid     (awid),
        .pcis_awaddr   (awaddr),
        .pcis_awlen    (awlen),
        .pcis_awvalid  (awvalid),
        .pcis_awready  (awready),
        .pcis_wvalid   (wvalid),
        .pcis_wready   (wready),
        .pcis_wlast    (wlast),
        .pcis_bid      (bid),
        .pcis_bresp    (bresp),
        .pcis_bvalid   (bvalid),
        .pcis_bready   (bready),
        .pcis_req_wr   (req_wr),
        .pcis_req_addr (req_addr),
        .wlast_error   (wlast_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic aw(input logic [15:0] id, input logic [63:0] a, input logic [7:0] l);
        awid    = id;
        awaddr  = a;
        awlen   = l;
        awvalid = 1'b1;
        chk("aw_ready", 64'(awready), 64'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic beat(input logic last);
        wvalid = 1'b1;
        wready = 1'b1;
        wlast  = last;
        tick();
        wvalid = 1'b0;
        wready = 1'b0;
        wlast  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wvalid = 1'b0; wready = 1'b0; wlast = 1'b0; bready = 1'b0;
        tick();
        tick();
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_req_wr", 64'(req_wr), 64'd0);
        chk("rst_req_addr", req_addr, 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_bid", 64'(bid), 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        chk("rst_wlast_err", 64'(wlast_err), 64'd0);
        rst = 1'b0;
        tick();

        // 1: four aligned beats
        aw(16'd5, 64'h1000, 8'd3);
        chk("t1_req_wr", 64'(req_wr), 64'd1);
        chk("t1_awready_busy", 64'(awready), 64'd0);
        chk("t1_addr0", req_addr, 64'h1000);
        beat(1'b0);
        chk("t1_addr1", req_addr, 64'h1040);
        beat(1'b0);
        chk("t1_addr2", req_addr, 64'h1080);
        beat(1'b0);
        chk("t1_addr3", req_addr, 64'h10C0);
        beat(1'b1);
        chk("t1_req_wr_end", 64'(req_wr), 64'd0);
        chk("t1_bvalid", 64'(bvalid), 64'd1);
        chk("t1_bid", 64'(bid), 64'd5);
        chk("t1_bresp", 64'(bresp), 64'd0);
        chk("t1_wlast_err", 64'(wlast_err), 64'd0);
        chk("t1_awready_back", 64'(awready), 64'd1);
        bready = 1'b1;
        tick();
        chk("t1_bpop", 64'(bvalid), 64'd0);

        // 2: unaligned start
        aw(16'd7, 64'h1010, 8'd1);
        chk("t2_addr0", req_addr, 64'h1010);
        beat(1'b0);
        chk("t2_addr1", req_addr, 64'h1040);
        beat(1'b1);
        chk("t2_bid", 64'(bid), 64'd7);
        tick();
        chk("t2_bpop", 64'(bvalid), 64'd0);

        // 3: fill the B FIFO, then drain in order
        bready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            aw(16'(16'h11 + i), 64'h2000, 8'd0);
            chk("t3_req_wr", 64'(req_wr), 64'd1);
            beat(1'b1);
        end
        chk("t3_full_awready", 64'(awready), 64'd0);
        awvalid = 1'b1;
        awid    = 16'h99;
        tick();
        chk("t3_no_accept", 64'(req_wr), 64'd0);
        awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_bvalid", 64'(bvalid), 64'd1);
            chk("t3_bid_order", 64'(bid), 64'(16'h11 + i));
            bready = 1'b1;
            tick();
            if (i == 0) chk("t3_awready_after_pop", 64'(awready), 64'd1);
        end
        chk("t3_drained", 64'(bvalid), 64'd0);

        // 4: early wlast
        bready = 1'b0;
        aw(16'd9, 64'h3000, 8'd2);
        beat(1'b0);
        chk("t4_no_err0", 64'(wlast_err), 64'd0);
        beat(1'b1);
        chk("t4_err_pulse", 64'(wlast_err), 64'd1);
        chk("t4_still_wr", 64'(req_wr), 64'd1);
        chk("t4_addr2", req_addr, 64'h3080);
        beat(1'b1);
        chk("t4_err_clear", 64'(wlast_err), 64'd0);
        chk("t4_req_wr_end", 64'(req_wr), 64'd0);
        chk("t4_bid", 64'(bid), 64'd9);
        bready = 1'b1;
        tick();
        chk("t4_single_b", 64'(bvalid), 64'd0);

        // 5: reset mid-burst with two Bs pending
        bready = 1'b0;
        aw(16'h21, 64'h0, 8'd0);
        beat(1'b1);
        aw(16'h22, 64'h0, 8'd0);
        beat(1'b1);
        aw(16'h23, 64'h4000, 8'd3);
        beat(1'b0);
        wvalid = 1'b1;
        wready = 1'b1;
        rst    = 1'b1;
        tick();
        wvalid = 1'b0;
        wready = 1'b0;
        chk("t5_req_wr", 64'(req_wr), 64'd0);
        chk("t5_bvalid", 64'(bvalid), 64'd0);
        chk("t5_awready", 64'(awready), 64'd0);
        chk("t5_req_addr", req_addr, 64'd0);
        rst = 1'b0;
        tick();
        aw(16'h24, 64'h5000, 8'd0);
        chk("t5_new_addr", req_addr, 64'h5000);
        beat(1'b1);
        chk("t5_new_bid", 64'(bid), 64'h24);
        bready = 1'b1;
        tick();
        chk("t5_only_one_b", 64'(bvalid), 64'd0);

        // 6: address wrap
        aw(16'd3, 64'hFFFF_FFFF_FFFF_FFC0, 8'd1);
        chk("t6_addr0", req_addr, 64'hFFFF_FFFF_FFFF_FFC0);
        beat(1'b0);
        chk("t6_wrap", req_addr, 64'h0);
        beat(1'b1);
        chk("t6_bid", 64'(bid), 64'd3);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
